dac_stream_tx: RTL and testbench

- Transmit-side counterpart of the board's 16-channel ADC capture path.
- Accepts 16-bit two's-complement samples from fabric over a valid/ready handshake and buffers them in an internal FIFO.
- Presents the samples to one parallel 16-bit DAC at a fixed sample rate of CLK/DIV.
- Generates the DAC's sample clock and reports underflow.

---
 rtl/dac_stream_tx.sv | 162 ++++++++++++++++
 tb/tb_dac_stream_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_tx.sv
// FIFO-buffered sample streamer driving a parallel DAC at CLK/DIV.
// Optional macro DAC_OFFSET_BINARY_EN selects offset-binary output coding (midscale 16'h8000).
module dac_stream_tx #(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int DIV         = 4,
  parameter int PRIME_LEVEL = 8
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ENABLE,
  input  logic [DATA_W-1:0]           DIN,
  input  logic                        DIN_VALID,
  output logic                        DIN_READY,
  output logic [DATA_W-1:0]           DAC_DATA,
  output logic                        DAC_CLK,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        RUNNING,
  output logic                        UNDERFLOW,
  input  logic                        UNDERFLOW_CLR
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(DIV);
  localparam logic [AW:0]   PRIME_CNT  = (AW+1)'(PRIME_LEVEL);
  localparam logic [AW:0]   DEPTH_CNT  = (AW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PHASE = PW'(DIV - 1);
  localparam logic [PW-1:0] HALF_PHASE = PW'(DIV / 2);

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [DATA_W-1:0] MIDSCALE = {1'b1, {(DATA_W-1){1'b0}}};
`else
  localparam logic [DATA_W-1:0] MIDSCALE = {DATA_W{1'b0}};
`endif

  function automatic logic [DATA_W-1:0] to_dac(input logic [DATA_W-1:0] s);
`ifdef DAC_OFFSET_BINARY_EN
    return {~s[DATA_W-1], s[DATA_W-2:0]};
`else
    return s;
`endif
  endfunction

  typedef enum logic [1:0] {IDLE = 2'd0, PRIME = 2'd1, RUN = 2'd2} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_next;
  logic [PW-1:0]     phase;
  logic [PW-1:0]     phase_next;
  logic              strobe;
  logic              push;
  logic              pop;
  logic              starve;

  assign FIFO_LEVEL = count;

  // Handshake, strobe and FIFO bookkeeping; a coincident push is never visible to the pop.
  always_comb begin
    strobe = (phase == LAST_PHASE);
    push   = DIN_VALID && DIN_READY;
    pop    = 1'b0;
    starve = 1'b0;
    if (ENABLE && strobe) begin
      case (state)
        PRIME:   pop = (count >= PRIME_CNT);
        RUN: begin
          pop    = (count != {(AW+1){1'b0}});
          starve = (count == {(AW+1){1'b0}});
        end
        default: pop = 1'b0;
      endcase
    end else begin
      pop    = 1'b0;
      starve = 1'b0;
    end
    count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    if (state == IDLE && ENABLE) begin
      phase_next = {PW{1'b0}};
    end else if (strobe) begin
      phase_next = {PW{1'b0}};
    end else begin
      phase_next = phase + PW'(1);
    end
  end

  // Sample storage; stale contents are harmless because the pointers are reset.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= DIN;
    end
  end

  // Control FSM, pointers and all registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      phase     <= {PW{1'b0}};
      wr_ptr    <= {AW{1'b0}};
      rd_ptr    <= {AW{1'b0}};
      count     <= {(AW+1){1'b0}};
      DIN_READY <= 1'b0;
      DAC_DATA  <= MIDSCALE;
      DAC_CLK   <= 1'b0;
      RUNNING   <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      phase     <= phase_next;
      count     <= count_next;
      DIN_READY <= (count_next < DEPTH_CNT);
      // The next state is non-IDLE exactly when ENABLE is high, so it gates the DAC clock.
      DAC_CLK   <= ENABLE && (phase_next >= HALF_PHASE);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (starve) begin
        UNDERFLOW <= 1'b1;
      end else if (UNDERFLOW_CLR) begin
        UNDERFLOW <= 1'b0;
      end
      case (state)
        IDLE: begin
          DAC_DATA <= MIDSCALE;
          RUNNING  <= 1'b0;
          if (ENABLE) begin
            state <= PRIME;
          end
        end
        PRIME: begin
          if (!ENABLE) begin
            state <= IDLE;
          end else if (pop) begin
            state    <= RUN;
            RUNNING  <= 1'b1;
            DAC_DATA <= to_dac(mem[rd_ptr]);
          end
        end
        RUN: begin
          if (!ENABLE) begin
            state    <= IDLE;
            RUNNING  <= 1'b0;
            DAC_DATA <= MIDSCALE;
          end else if (pop) begin
            DAC_DATA <= to_dac(mem[rd_ptr]);
          end
        end
        default: begin
          state    <= IDLE;
          RUNNING  <= 1'b0;
          DAC_DATA <= MIDSCALE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dac_stream_tx.sv
// Randomized scoreboard bench for dac_stream_tx against a queue-based reference model.
module tb_dac_stream_tx;
  localparam int DATA_W      = 16;
  localparam int FIFO_DEPTH  = 16;
  localparam int DIV         = 4;
  localparam int PRIME_LEVEL = 8;

`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [15:0] MID = 16'h8000;
`else
  localparam logic [15:0] MID = 16'h0000;
`endif

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ENABLE = 1'b0;
  logic [15:0] DIN = 16'h0000;
  logic        DIN_VALID = 1'b0;
  logic        UNDERFLOW_CLR = 1'b0;
  logic        DIN_READY;
  logic [15:0] DAC_DATA;
  logic        DAC_CLK;
  logic [4:0]  FIFO_LEVEL;
  logic        RUNNING;
  logic        UNDERFLOW;

  dac_stream_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .DIV(DIV), .PRIME_LEVEL(PRIME_LEVEL)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIN(DIN), .DIN_VALID(DIN_VALID),
    .DIN_READY(DIN_READY), .DAC_DATA(DAC_DATA), .DAC_CLK(DAC_CLK), .FIFO_LEVEL(FIFO_LEVEL),
    .RUNNING(RUNNING), .UNDERFLOW(UNDERFLOW), .UNDERFLOW_CLR(UNDERFLOW_CLR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offset binary is the sample shifted up by half of full scale, modulo 2^16.
  function automatic logic [15:0] xform(input logic [15:0] s);
`ifdef DAC_OFFSET_BINARY_EN
    return s + 16'h8000;
`else
    return s;
`endif
  endfunction

  // Reference model: 0 = idle, 1 = priming, 2 = streaming.
  int          m_state = 0;
  int          m_phase = 0;
  bit          m_ready = 1'b0;
  bit          m_uf = 1'b0;
  bit          m_clk = 1'b0;
  bit          model_init = 1'b0;
  logic [15:0] m_dac = MID;
  logic [15:0] m_q[$];
  logic [15:0] exp_q[$];

  always @(posedge CLK) begin : model
    int sz;
    bit strb;
    bit set_uf;
    if (RESET) begin
      model_init = 1'b1;
      m_state = 0; m_phase = 0; m_ready = 1'b0; m_uf = 1'b0; m_clk = 1'b0; m_dac = MID;
      m_q.delete(); exp_q.delete();
    end else begin
      sz     = m_q.size();
      strb   = (m_state != 0) && (m_phase == DIV - 1);
      set_uf = 1'b0;
      case (m_state)
        0: begin
          if (ENABLE) begin m_state = 1; m_phase = 0; end
          else m_phase = (m_phase + 1) % DIV;
        end
        1: begin
          if (!ENABLE) begin m_state = 0; exp_q.delete(); end
          else if (strb && sz >= PRIME_LEVEL) begin
            m_state = 2; m_dac = xform(m_q.pop_front()); exp_q.push_back(m_dac);
          end
          m_phase = (m_phase + 1) % DIV;
        end
        default: begin
          if (!ENABLE) begin m_state = 0; m_dac = MID; exp_q.delete(); end
          else if (strb) begin
            if (sz > 0) m_dac = xform(m_q.pop_front());
            else set_uf = 1'b1;
            exp_q.push_back(m_dac);
          end
          m_phase = (m_phase + 1) % DIV;
        end
      endcase
      if (set_uf) m_uf = 1'b1;
      else if (UNDERFLOW_CLR) m_uf = 1'b0;
      if (DIN_VALID && m_ready) m_q.push_back(DIN);
      m_ready = (m_q.size() < FIFO_DEPTH);
      m_clk   = (m_state != 0) && (m_phase >= DIV / 2);
    end
  end

  // Per-cycle status comparison against the model.
  always @(negedge CLK) begin
    if (model_init) begin
      check("fifo_level", FIFO_LEVEL, m_q.size());
      check("din_ready", DIN_READY, m_ready);
      check("running", RUNNING, m_state == 2);
      check("underflow", UNDERFLOW, m_uf);
      check("dac_data", DAC_DATA, m_dac);
      check("dac_clk", DAC_CLK, m_clk);
    end
  end

  // Scoreboard monitor: each DAC_CLK rising edge in RUN presents one sample.
  bit prev_clk = 1'b0;
  always @(negedge CLK) begin
    if (model_init && DAC_CLK && !prev_clk) begin
      if (exp_q.size() > 0) check("sb_sample", DAC_DATA, exp_q.pop_front());
      else if (RUNNING) check("sb_unexpected_sample", 32'd1, 32'd0);
    end
    prev_clk = DAC_CLK;
  end

  // Source: holds each sample on DIN until a handshake completes.
  logic [15:0] src_q[$];
  bit          src_en = 1'b0;
  bit          fire = 1'b0;

  task automatic tick();
    @(negedge CLK);
    if (fire) void'(src_q.pop_front());
    DIN_VALID = src_en && (src_q.size() > 0);
    DIN       = (src_q.size() > 0) ? src_q[0] : 16'($urandom);
    fire      = DIN_VALID && DIN_READY;
  endtask

  logic [15:0] last_s;

  initial begin
    RESET = 1'b1;
    repeat (3) tick();
    check("ready_in_reset", DIN_READY, 1'b0);
    RESET = 1'b0;
    tick();
    check("ready_after_reset", DIN_READY, 1'b1);
    repeat (12) tick();
    check("idle_dac_clk", DAC_CLK, 1'b0);

    // Backpressure while idle.
    for (int i = 0; i < 20; i++) begin
      last_s = 16'($urandom);
      src_q.push_back(last_s);
    end
    src_en = 1'b1;
    repeat (30) tick();
    check("bp_level", FIFO_LEVEL, 5'd16);
    check("bp_ready", DIN_READY, 1'b0);
    check("bp_held", src_q.size(), 4);

    // Stream everything out and starve.
    ENABLE = 1'b1;
    for (int i = 0; i < 400 && !(UNDERFLOW && src_q.size() == 0); i++) tick();
    check("uf_set", UNDERFLOW, 1'b1);
    check("uf_hold_last", DAC_DATA, xform(last_s));
    for (int i = 0; i < DIV && m_phase != 1; i++) tick();
    UNDERFLOW_CLR = 1'b1; tick(); UNDERFLOW_CLR = 1'b0;
    check("uf_cleared", UNDERFLOW, 1'b0);
    for (int i = 0; i < DIV && m_phase != DIV - 1; i++) tick();
    UNDERFLOW_CLR = 1'b1; tick(); UNDERFLOW_CLR = 1'b0;
    check("uf_set_wins", UNDERFLOW, 1'b1);

    // Prime with 1..8, then disable with 5 queued, then reset.
    ENABLE = 1'b0;
    RESET = 1'b1; repeat (2) tick(); RESET = 1'b0;
    ENABLE = 1'b1;
    for (int i = 1; i <= 8; i++) src_q.push_back(16'(i));
    for (int i = 0; i < 200 && !RUNNING; i++) tick();
    check("prime_running", RUNNING, 1'b1);
    check("prime_first", DAC_DATA, xform(16'h0001));
    for (int i = 0; i < 200 && m_q.size() != 5; i++) tick();
    ENABLE = 1'b0;
    repeat (3) tick();
    check("dis_level", FIFO_LEVEL, 5'd5);
    check("dis_mid", DAC_DATA, MID);
    check("dis_running", RUNNING, 1'b0);
    RESET = 1'b1; tick(); RESET = 1'b0;
    check("rst_level", FIFO_LEVEL, 5'd0);

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 59) == 0) ENABLE = ~ENABLE;
      if (src_q.size() < 4 && $urandom_range(0, 7) == 0)
        repeat ($urandom_range(1, 6)) src_q.push_back(16'($urandom));
      src_en = ($urandom_range(0, 5) != 0);
      UNDERFLOW_CLR = ($urandom_range(0, 29) == 0);
      RESET = ($urandom_range(0, 499) == 0);
      tick();
    end
    RESET = 1'b0; UNDERFLOW_CLR = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
